// File: rtl/timer_dev.sv
// timer_dev: bus-mapped down-counting timer with maskable irq; define TIMER_DEV_STATUS_EN to add the STATUS register at offset 0xC
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset, r_count, w_status;
  logic        r_irq_flag;
  logic [1:0]  w_sel;
  logic        w_wr_ctrl, w_wr_preset, w_auto, w_set, w_clr, w_ack, w_unused;
  assign w_sel       = addr[3:2];
  assign w_unused    = &{1'b0, addr[31:4], addr[1:0]};
  assign w_wr_ctrl   = we && w_sel == 2'd0;
  assign w_wr_preset = we && w_sel == 2'd1;
  assign w_auto      = r_ctrl[2:1] == 2'b01;
  assign w_set       = r_state == CNT && r_ctrl[0] && r_count <= 32'd1;
`ifdef TIMER_DEV_STATUS_EN
  assign w_ack    = we && w_sel == 2'd3 && wdata[1];
  assign w_status = {30'b0, r_irq_flag, r_state == CNT};
`else
  assign w_ack    = 1'b0;
  assign w_status = '0;
`endif
  assign w_clr = w_wr_ctrl || w_wr_preset || w_ack || (r_state == INT && w_auto);
  assign rdata = w_sel == 2'd0 ? {28'b0, r_ctrl} :
                 w_sel == 2'd1 ? r_preset :
                 w_sel == 2'd2 ? r_count : w_status;
  assign irq   = r_ctrl[3] & r_irq_flag;
  always_comb begin
    w_next = r_state == IDLE ? (r_ctrl[0] ? LOAD : IDLE) :
             r_state == LOAD ? CNT :
             r_state == CNT  ? (!r_ctrl[0] ? IDLE : w_set ? INT : CNT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= wdata[3:0];
      else if (r_state == INT && !w_auto) r_ctrl[0] <= 1'b0;
      if (w_wr_preset) r_preset <= wdata;
      if (r_state == LOAD) r_count <= r_preset;
      else if (r_state == CNT && r_ctrl[0]) r_count <= w_set ? 32'd0 : r_count - 32'd1;
      r_irq_flag <= w_set | (r_irq_flag & ~w_clr);
    end
  end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: randomized and directed checks of timer_dev against a phase-based timeline model; honours TIMER_DEV_STATUS_EN
module tb_timer_dev;
  logic        clk = 1'b0, reset = 1'b0, we = 1'b0, irq;
  logic [31:0] addr = '0, wdata = '0, rdata, v;
  int          tests = 0, fails = 0;
  bit          found;
  timer_dev dut (.clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .irq(irq));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0;
    reset = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
  endtask
  // Cycle k after the CTRL write falls in phase ph of a period LOAD, pe*CNT, INT, IDLE
  task automatic run_trial(input int p, input logic [1:0] m, input logic im, input int ncyc, input bit poke);
    int pe, len, ph, ecnt;
    bit auto_m, eirq;
    logic [31:0] ctl, ectl, r;
    do_reset();
    wr(32'h4, 32'(p));
    ctl = {28'b0, im, m, 1'b1};
    wr(32'h0, ctl);
    pe = p < 1 ? 1 : p;
    len = pe + 3;
    auto_m = m == 2'b01;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      ph = auto_m ? (k - 1) % len : ((k - 1) < len - 1 ? k - 1 : len - 1);
      ecnt = (ph >= 1 && ph <= pe) ? p - (ph - 1) : 0;
      eirq = auto_m ? (im && ph == pe + 1) : (im && ph >= pe + 1);
      ectl = (!auto_m && ph >= pe + 2) ? (ctl & ~32'h1) : ctl;
      rd(32'h8, r); chk("count", r, 32'(ecnt));
      chk("irq", {31'b0, irq}, {31'b0, eirq});
      rd(32'h0, r); chk("ctrl", r, ectl);
      if (poke && $urandom_range(0, 2) == 0) begin
        addr = 32'h8; wdata = $urandom; we = 1'b1;
      end
    end
    we = 1'b0;
  endtask
  initial begin
    do_reset();
    rd(32'h0, v); chk("rst_ctrl", v, 32'h0);
    rd(32'h4, v); chk("rst_preset", v, 32'h0);
    rd(32'h8, v); chk("rst_count", v, 32'h0);
    rd(32'hC, v); chk("rst_status", v, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    run_trial(3, 2'b00, 1'b1, 12, 1'b0);
    chk("oneshot_hold_irq", {31'b0, irq}, 32'h1);
    wr(32'h0, 32'h0);
    chk("oneshot_clr_irq", {31'b0, irq}, 32'h0);
    rd(32'h0, v); chk("oneshot_ctrl0", v, 32'h0);
    run_trial(2, 2'b01, 1'b1, 16, 1'b1);
    run_trial(0, 2'b00, 1'b1, 8, 1'b0);
    run_trial(1, 2'b00, 1'b1, 3, 1'b0);
    wr(32'h0, 32'h9);
    rd(32'h0, v); chk("int_wr_wins", v, 32'h9);
    chk("int_wr_irq", {31'b0, irq}, 32'h0);
    step(); step();
    rd(32'h8, v); chk("int_wr_reload", v, 32'h1);
    for (int t = 0; t < 10; t++)
      run_trial(int'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 24, 1'b1);
    do_reset();
    wr(32'h4, 32'd10); wr(32'h0, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      rd(32'h8, v);
      found = v == 32'd5;
    end
    chk("reach_count5", {31'b0, found}, 32'h1);
    do_reset();
    rd(32'h0, v); chk("abort_ctrl", v, 32'h0);
    rd(32'h4, v); chk("abort_preset", v, 32'h0);
    rd(32'h8, v); chk("abort_count", v, 32'h0);
    chk("abort_irq", {31'b0, irq}, 32'h0);
    repeat (12) step();
    chk("abort_irq_late", {31'b0, irq}, 32'h0);
    do_reset();
    wr(32'h4, 32'd8); wr(32'h0, 32'h1);
    step(); step();
    wr(32'h8, 32'h1234);
    rd(32'h8, v); chk("count_wr_ignored", v, 32'd7);
    step();
    rd(32'h8, v); chk("count_continues", v, 32'd6);
    do_reset();
    wr(32'h4, 32'd4); wr(32'h0, 32'h1);
    step();
    wr(32'h0, 32'h0);
    rd(32'h8, v); chk("load_en0_count", v, 32'd4);
    step(); step(); step();
    rd(32'h8, v); chk("load_en0_held", v, 32'd4);
    chk("load_en0_irq", {31'b0, irq}, 32'h0);
    do_reset();
    wr(32'h4, 32'd5); wr(32'h0, 32'hB);
    step(); step();
    wr(32'h4, 32'd2);
    rd(32'h8, v); chk("preset_wr_cnt", v, 32'd4);
    repeat (7) step();
    rd(32'h8, v); chk("preset_next_load", v, 32'd2);
`ifdef TIMER_DEV_STATUS_EN
    run_trial(1, 2'b00, 1'b0, 6, 1'b0);
    rd(32'hC, v); chk("status_flag", v, 32'h2);
    chk("status_irq_masked", {31'b0, irq}, 32'h0);
    wr(32'hC, 32'h2);
    rd(32'hC, v); chk("status_ack", v, 32'h0);
    do_reset();
    wr(32'h4, 32'd4); wr(32'h0, 32'h1);
    step(); step();
    rd(32'hC, v); chk("status_cnt", v, 32'h1);
`else
    run_trial(1, 2'b00, 1'b1, 6, 1'b0);
    rd(32'hC, v); chk("rsvd_read", v, 32'h0);
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'hC, v); chk("rsvd_wr_ignored", v, 32'h0);
    chk("rsvd_irq_kept", {31'b0, irq}, 32'h1);
    rd(32'h0, v); chk("rsvd_ctrl_kept", v, 32'h8);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
